regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file (RW, BusW, RegWr; written on negedge Clk) among NUM_REQ writeback sources, e.g. ALU writeback and load writeback.
- Uses round-robin arbitration with an optional fixed-priority override for requester 0.
- Port outputs are registered on posedge Clk, so they are stable when the register file samples on the following negedge.
- Tracks accepted, performed and dropped writes for debug.

Parameters:
NUM_REQ, 2, number of writeback requesters; legal range 2..4.
CNT_W, 16, width of the write and drop counters.

Ports:
Clk  input  1  clock; all state updates on posedge.
Resetn  input  1  asynchronous, active-low reset.
req_valid  input  NUM_REQ  bit i: requester i presents a write.
req_rw  input  5*NUM_REQ  slice [5i+:5]: destination register of requester i.
req_data  input  32*NUM_REQ  slice [32i+:32]: write data of requester i.
req_ready  output  NUM_REQ  one-hot or zero grant; a transfer occurs when req_valid[i] & req_ready[i].
prio_en  input  1  1 = requester 0 has fixed priority over all others.
RegWr  output  1  register-file write enable, registered.
RW  output  5  register-file write address, registered.
BusW  output  32  register-file write data, registered.
wr_count  output  CNT_W  writes issued to the register file (wraps).
drop_count  output  CNT_W  accepted writes targeting R0 (wraps).

Behaviour:
- Reset (Resetn=0, asynchronous): RegWr=0, RW=0, BusW=0, rr_ptr=0, wr_count=0, drop_count=0.
- While Resetn=0, req_ready is held at 0.
- Grant (combinational, from req_valid, rr_ptr, prio_en):
  - If prio_en=1 and req_valid[0]=1, grant requester 0.
  - Otherwise grant the first valid requester searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready has at most one bit set.
  - req_ready is 0 for every requester when no req_valid bit is set.
- Requester contract:
  - req_valid, req_rw and req_data stay stable until accepted.
  - The arbiter never accepts more than one request per cycle.
- Accept (posedge, grant g exists):
  - RW <= req_rw[g]; BusW <= req_data[g].
  - RegWr <= 1 if req_rw[g] != 0.
  - rr_ptr <= (g+1) mod NUM_REQ, also under prio_en.
  - wr_count increments if req_rw[g] != 0; drop_count increments if req_rw[g] == 0.
- R0 writes: accepted (handshake completes) but RegWr=0.
  - RW and BusW still update.
  - wr_count unchanged.
- No grant: RegWr <= 0; RW and BusW hold their previous values; rr_ptr holds.
- Latency: request accepted at posedge k → RegWr high during cycle k..k+1 → register file writes at the negedge inside that cycle.
  - A read of that register through BusA/BusB is valid from the following posedge.
- Back-to-back: RegWr may stay high on consecutive cycles, carrying a different request each cycle. Throughput is one write per cycle.
- Same destination accepted in consecutive cycles: both are issued in acceptance order, so the later one wins.
- Counters wrap from 2^CNT_W-1 to 0 without flag.
- Reset mid-operation: a pending RegWr is cleared immediately (asynchronously). No write is issued after Resetn falls.
  - Unaccepted requests are not remembered; requesters re-present them after reset.
- Fairness: with prio_en=0 and all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- With prio_en=1, requester 0 may starve the others; this is intended.

Test Plan:
- Reset, then single request: req_valid=01, req_rw[0]=5, req_data[0]=0xDEADBEEF.
  - Required: req_ready=01 in the same cycle.
  - After posedge: RegWr=1, RW=5, BusW=0xDEADBEEF.
  - After the negedge, register 5 reads 0xDEADBEEF; wr_count=1.
- Both requesters continuously valid (rw 3/data 0x11 and rw 4/data 0x22), prio_en=0, 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; RW sequence 3,4,3,4,3,4; wr_count=6.
- Same as the previous scenario with prio_en=1 for 4 cycles.
  - Required: req_ready=01 every cycle; requester 1 is never granted.
  - After prio_en drops, the next grant goes to requester 1 (rr_ptr=1).
- Requester 1 writes R0 with data 0xFFFFFFFF.
  - Required: handshake completes, RegWr=0, drop_count=1, wr_count unchanged, R0 still reads 0.
- Resetn pulsed low mid-stream while RegWr=1.
  - Required: RegWr, RW, BusW and the counters go to 0 immediately, with no posedge needed.
  - No register is written at the next negedge.
  - After Resetn rises, arbitration restarts at requester 0.
- Counter wrap with CNT_W=4: 17 consecutive non-R0 writes.
  - Required: wr_count reads 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin (optional req0 priority) arbiter for the register-file write port; outputs registered, 1 cycle.
// Backpressure: at most one req_ready bit per cycle, all low while Resetn is asserted; losers hold their request.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_rw,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    prio_en,
  output logic                    RegWr,
  output logic [4:0]              RW,
  output logic [31:0]             BusW,
  output logic [CNT_W-1:0]        wr_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int PTR_W = 2;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               regwr_q, regwr_d;
  logic [4:0]         rw_q, rw_d;
  logic [31:0]        busw_q, busw_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [4:0]         sel_rw;
  logic [31:0]        sel_data;
  logic               sel_r0;

  // Offset k from rr_ptr is searched in order; requester i sits at offset k when rr_ptr == (i-k) mod NUM_REQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (prio_en && req_valid[0]) begin
      gnt[0] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && req_valid[i] &&
              rr_ptr_q == PTR_W'((i - k + NUM_REQ) % NUM_REQ)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    sel_rw   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_rw   = req_rw[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  assign gnt_any   = |gnt;
  assign sel_r0    = (sel_rw == 5'd0);
  assign req_ready = Resetn ? gnt : '0;

  // R0 targets complete the handshake but never raise RegWr; they are counted as drops instead.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    regwr_d    = 1'b0;
    rw_d       = rw_q;
    busw_d     = busw_q;
    wr_cnt_d   = wr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      rw_d     = sel_rw;
      busw_d   = sel_data;
      if (sel_r0) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        regwr_d  = 1'b1;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rr_ptr_q   <= '0;
      regwr_q    <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      regwr_q    <= regwr_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign RegWr      = regwr_q;
  assign RW         = rw_q;
  assign BusW       = busw_q;
  assign wr_count   = wr_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reference model predicts grants and register-file port state;
// a monitor pops predicted port state after each posedge and compares it with the DUT.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int CW = 4;

  logic            Clk;
  logic            Resetn;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_rw;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            prio_en;
  logic            RegWr;
  logic [4:0]      RW;
  logic [31:0]     BusW;
  logic [CW-1:0]   wr_count;
  logic [CW-1:0]   drop_count;

  regfile_write_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .prio_en    (prio_en),
    .RegWr      (RegWr),
    .RW         (RW),
    .BusW       (BusW),
    .wr_count   (wr_count),
    .drop_count (drop_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file fed by the DUT port, written on the falling edge.
  logic [31:0] rf [32];
  always @(negedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWr) begin
      rf[RW] <= BusW;
    end
  end

  typedef struct {
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] data;
    logic [3:0]  wr;
    logic [3:0]  drop;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_rr, m_wr, m_drop;
  logic [4:0]  m_rw;
  logic [31:0] m_data;

  // Pending request of each requester (held until granted)
  logic [N-1:0] pv;
  logic [4:0]   prw  [N];
  logic [31:0]  pdat [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_rr = 0; m_wr = 0; m_drop = 0; m_rw = '0; m_data = '0;
    pv = '0;
    sb.delete();
  endtask

  task automatic set_req(input int i, input logic [4:0] rw, input logic [31:0] d);
    pv[i] = 1'b1; prw[i] = rw; pdat[i] = d;
  endtask

  // One arbitration cycle: drive pending requests, check the grant, push predicted port state.
  task automatic cycle(input logic pe);
    int g;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge Clk);
    prio_en   = pe;
    req_valid = pv;
    for (int i = 0; i < N; i++) begin
      req_rw[5*i +: 5]    = prw[i];
      req_data[32*i +: 32] = pdat[i];
    end
    #1;
    g = -1;
    if (pe && pv[0]) g = 0;
    else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && pv[c]) g = c;
      end
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = (i == g);
    check("req_ready", req_ready, exp_rdy);
    e.regwr = 1'b0;
    if (g >= 0) begin
      m_rw   = prw[g];
      m_data = pdat[g];
      m_rr   = (g + 1) % N;
      if (prw[g] != 0) begin
        e.regwr = 1'b1;
        m_wr++;
      end else begin
        m_drop++;
      end
      pv[g] = 1'b0;
    end
    e.rw   = m_rw;
    e.data = m_data;
    e.wr   = 4'(m_wr % 16);
    e.drop = 4'(m_drop % 16);
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (Resetn && sb.size() > 0) begin
        e = sb.pop_front();
        check("RegWr", RegWr, e.regwr);
        check("RW", RW, e.rw);
        check("BusW", BusW, e.data);
        check("wr_count", wr_count, e.wr);
        check("drop_count", drop_count, e.drop);
      end
    end
  end

  logic [31:0] snap [32];

  initial begin
    int bad;
    Resetn = 1'b0; prio_en = 1'b0; req_valid = '1; req_rw = '1; req_data = '1;
    model_reset();
    for (int i = 0; i < N; i++) begin prw[i] = '0; pdat[i] = '0; end
    #12;
    check("rst_RegWr", RegWr, 0);
    check("rst_RW", RW, 0);
    check("rst_BusW", BusW, 0);
    check("rst_wr", wr_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ready", req_ready, 0);
    req_valid = '0;
    #1 Resetn = 1'b1;

    // Single write
    set_req(0, 5'd5, 32'hDEADBEEF);
    cycle(1'b0);
    cycle(1'b0);
    check("rf5", rf[5], 32'hDEADBEEF);
    check("wr_one", wr_count, 1);

    // Alternation with prio_en=0
    for (int c = 0; c < 6; c++) begin
      set_req(0, 5'd3, 32'h11); set_req(1, 5'd4, 32'h22);
      cycle(1'b0);
    end
    // Priority override, then release
    for (int c = 0; c < 4; c++) begin
      set_req(0, 5'd3, 32'h11); set_req(1, 5'd4, 32'h22);
      cycle(1'b1);
    end
    set_req(0, 5'd3, 32'h11); set_req(1, 5'd4, 32'h22);
    cycle(1'b0);
    check("after_prio", req_ready, 3'b010);
    pv = '0;
    cycle(1'b0);

    // R0 drop
    set_req(1, 5'd0, 32'hFFFFFFFF);
    cycle(1'b0);
    pv = '0;
    cycle(1'b0);
    check("rf0", rf[0], 0);

    // Reset while a write is on the port
    set_req(0, 5'd9, 32'hA5A50001);
    cycle(1'b0);
    @(posedge Clk); #3;
    check("pre_rst_RegWr", RegWr, 1);
    Resetn = 1'b0;
    #1;
    check("mid_rst_RegWr", RegWr, 0);
    check("mid_rst_RW", RW, 0);
    check("mid_rst_BusW", BusW, 0);
    check("mid_rst_wr", wr_count, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_ready", req_ready, 0);
    for (int i = 0; i < 32; i++) snap[i] = rf[i];
    @(negedge Clk); #1;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== snap[i]) bad++;
    check("rst_no_write", bad, 0);
    @(posedge Clk); #1;
    check("rst_hold_RegWr", RegWr, 0);
    req_valid = '0;
    model_reset();
    #1 Resetn = 1'b1;

    // Restart at requester 0, then 17 writes wrap the 4-bit counter
    for (int c = 0; c < 17; c++) begin
      if (!pv[0]) set_req(0, 5'(1 + (c % 31)), $urandom);
      if (!pv[1]) set_req(1, 5'(1 + ((c * 7) % 31)), $urandom);
      cycle(1'b0);
    end
    pv = '0;
    cycle(1'b0);
    check("wrap", wr_count, 17 % 16);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6)
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
      end
      cycle($urandom_range(0, 9) < 2);
    end
    pv = '0;
    cycle(1'b0);
    cycle(1'b0);
    @(posedge Clk); #2;
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
